// File: rtl/fib_req_initiator.sv
// Initiator for the fibonacci start/nth/result/out_en core interface.
// Requests (nth) are queued in a small FIFO, issued to the core one at a
// time, and answered with {nth, result, timeout} on a valid/ready port.
// Optional build macro: FIB_CHECK_EN adds an iterative reference engine and
// drives rsp_mismatch when the core's answer disagrees with it.
module fib_req_initiator #(
    parameter int NTH_W      = 8,
    parameter int RES_W      = 20,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [NTH_W-1:0] req_nth,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [NTH_W-1:0] rsp_nth,
    output logic [RES_W-1:0] rsp_result,
    output logic             rsp_timeout,
    output logic             rsp_mismatch,
    output logic [NTH_W-1:0] fib_nth,
    output logic             fib_start,
    input  logic [RES_W-1:0] fib_result,
    input  logic             fib_out_en,
    output logic             busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t           state, state_nxt;
    logic [NTH_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop, go_resp;
    logic [NTH_W-1:0] head_nth, cur_nth;
    logic             prev_out_en, captured, capture, done_cap, calc_done;
    logic [RES_W-1:0] cap_res, cap_val;
    logic [TW-1:0]    timer, timer_inc;
    logic             tmo_hit, mm_nxt;
    logic             rsp_mismatch_q;

    assign req_ready = (count != (AW+1)'(FIFO_DEPTH));
    assign push      = req_valid && req_ready;
    assign head_nth  = fifo_mem[rd_ptr];
    assign busy      = (state != S_IDLE) || (count != '0);
    assign fib_nth   = cur_nth;

    // Only a fresh rising edge of out_en inside WAIT counts as the answer.
    assign capture   = (state == S_WAIT) && fib_out_en && !prev_out_en && !captured;
    assign done_cap  = capture || captured;
    assign cap_val   = captured ? cap_res : fib_result;
    assign timer_inc = timer + 1'b1;
    // A capture in the same cycle as the timer expiring wins over the timeout.
    assign tmo_hit   = (state == S_WAIT) && !done_cap && (timer_inc == TW'(TIMEOUT));

`ifdef FIB_CHECK_EN
    logic [RES_W-1:0] eng_a0, eng_a1, eng_sum;
    logic [NTH_W-1:0] eng_cnt;
    logic             eng_done;

    assign eng_done  = (eng_cnt == '0);
    assign calc_done = done_cap && eng_done;
    assign mm_nxt    = (cap_val != eng_sum);

    // Reference engine: loads in START, then one term of sum(F1..Fn) per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_a0  <= '0;
            eng_a1  <= '0;
            eng_sum <= '0;
            eng_cnt <= '0;
        end else if (state == S_START) begin
            eng_a0  <= '0;
            eng_a1  <= RES_W'(1);
            eng_sum <= '0;
            eng_cnt <= cur_nth;
        end else if ((state == S_WAIT) && !eng_done) begin
            eng_sum <= eng_sum + eng_a1;
            eng_a0  <= eng_a1;
            eng_a1  <= eng_a0 + eng_a1;
            eng_cnt <= eng_cnt - 1'b1;
        end
    end
`else
    assign calc_done = capture;
    assign mm_nxt    = 1'b0;
`endif

    assign rsp_mismatch = rsp_mismatch_q;

    // Request FIFO storage and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= req_nth;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and strobe outputs.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        go_resp   = 1'b0;
        fib_start = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = (head_nth == '0) ? S_RESP : S_START;
                end
            end
            S_START: begin
                fib_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (calc_done || tmo_hit) begin
                    go_resp   = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latched request, wait timer, result capture and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_nth        <= '0;
            prev_out_en    <= 1'b0;
            captured       <= 1'b0;
            cap_res        <= '0;
            timer          <= '0;
            rsp_nth        <= '0;
            rsp_result     <= '0;
            rsp_timeout    <= 1'b0;
            rsp_mismatch_q <= 1'b0;
        end else begin
            prev_out_en <= fib_out_en;
            if (pop) begin
                cur_nth <= head_nth;
                if (head_nth == '0) begin
                    rsp_nth        <= '0;
                    rsp_result     <= '0;
                    rsp_timeout    <= 1'b0;
                    rsp_mismatch_q <= 1'b0;
                end
            end
            if (state == S_START) begin
                timer    <= '0;
                captured <= 1'b0;
            end
            if (state == S_WAIT) begin
                if (!done_cap) timer <= timer_inc;
                if (capture) begin
                    captured <= 1'b1;
                    cap_res  <= fib_result;
                end
                if (go_resp) begin
                    rsp_nth        <= cur_nth;
                    rsp_result     <= tmo_hit ? '0 : cap_val;
                    rsp_timeout    <= tmo_hit;
                    rsp_mismatch_q <= !tmo_hit && mm_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_fib_req_initiator.sv
// Testbench for fib_req_initiator: directed scenarios followed by randomized
// requests, with a behavioural fibonacci core and a response scoreboard.
`timescale 1ns/1ps
module tb_fib_req_initiator;

    localparam int NTH_W = 8;
    localparam int RES_W = 20;
    localparam int DEPTH = 4;
    localparam int TMO   = 15;
    localparam longint MASK = (longint'(1) << RES_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [NTH_W-1:0] req_nth = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [NTH_W-1:0] rsp_nth;
    logic [RES_W-1:0] rsp_result;
    logic             rsp_timeout;
    logic             rsp_mismatch;
    logic [NTH_W-1:0] fib_nth;
    logic             fib_start;
    logic [RES_W-1:0] fib_result = '0;
    logic             fib_out_en = 1'b0;
    logic             busy;

    fib_req_initiator #(.NTH_W(NTH_W), .RES_W(RES_W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_nth(req_nth),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_nth(rsp_nth),
        .rsp_result(rsp_result), .rsp_timeout(rsp_timeout), .rsp_mismatch(rsp_mismatch),
        .fib_nth(fib_nth), .fib_start(fib_start), .fib_result(fib_result),
        .fib_out_en(fib_out_en), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int nth; int ans; int lat; bit mute; } core_t;
    typedef struct { int nth; int res; int to; int mm; } rsp_t;

    core_t core_q[$];
    rsp_t  exp_q[$];
    int    start_log[$];
    int    start_cyc = 0;
    int    rsp_cyc = 0;
    int    last_wait = 0;
    int    checks = 0;
    int    errors = 0;

    // sum(F1..Fn) = F(n+2) - 1, reduced mod 2^RES_W
    function automatic int ref_sum(input int n);
        longint a = 0, b = 1, t;
        for (int i = 0; i < n + 2; i++) begin
            t = (a + b) & MASK;
            a = b;
            b = t;
        end
        return int'((a + MASK) & MASK);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Behavioural core: answers each start after lat cycles with one out_en pulse.
    always begin : core_model
        core_t c;
        @(negedge clk);
        if (fib_start && !reset) begin
            start_log.push_back(int'(fib_nth));
            start_cyc = cyc;
            if (core_q.size() != 0) c = core_q.pop_front();
            else c = '{0, 0, 0, 1'b1};
            if (!c.mute) begin
                repeat (c.lat) begin
                    @(negedge clk);
                    chk("fib_nth_hold", fib_nth, c.nth);
                    chk("fib_start_pulse", fib_start, 0);
                end
                fib_result = c.ans[RES_W-1:0];
                fib_out_en = 1'b1;
                @(negedge clk);
                fib_out_en = 1'b0;
                fib_result = '0;
            end
        end
    end

    task automatic push(input int n, input int ans, input int lat, input bit mute);
        rsp_t  e;
        core_t c;
        int    r;
        chk("req_ready_on_push", req_ready, 1);
        req_valid = 1'b1;
        req_nth   = n[NTH_W-1:0];
        @(negedge clk);
        req_valid = 1'b0;
        r = ref_sum(n);
        if (n == 0) e = '{0, 0, 0, 0};
        else begin
            c = '{n, ans, lat, mute};
            core_q.push_back(c);
            if (mute) e = '{n, 0, 1, 0};
            else begin
                e = '{n, int'(longint'(ans) & MASK), 0, 0};
`ifdef FIB_CHECK_EN
                e.mm = (e.res != r) ? 1 : 0;
`endif
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic expect_rsp(input int hold);
        rsp_t e;
        int   waited = 0;
        while (!rsp_valid && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        last_wait = waited;
        rsp_cyc   = cyc;
        if (!rsp_valid) begin
            chk("rsp_valid_wait", rsp_valid, 1);
            return;
        end
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = '{-1, -1, -1, -1};
        chk("rsp_nth", rsp_nth, e.nth);
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_timeout", rsp_timeout, e.to);
        chk("rsp_mismatch", rsp_mismatch, e.mm);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk("rsp_hold_valid", rsp_valid, 1);
            chk("rsp_hold_nth", rsp_nth, e.nth);
            chk("rsp_hold_result", rsp_result, e.res);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n0, n, lat, ans;
        bit mute;

        // Reset pulse of 100 ps, then all outputs idle
        #1 reset = 1'b1;
        #0.1 reset = 1'b0;
        #0.1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_nth", rsp_nth, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_rsp_mismatch", rsp_mismatch, 0);
        chk("rst_fib_nth", fib_nth, 0);
        chk("rst_fib_start", fib_start, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);

        // Single request nth=10
        n0 = start_log.size();
        push(10, ref_sum(10), 3, 1'b0);
        expect_rsp(0);
        chk("t2_start_count", start_log.size() - n0, 1);
        chk("t2_start_nth", start_log[$], 10);

        // Back-to-back nth=1, nth=5
        n0 = start_log.size();
        push(1, ref_sum(1), 2, 1'b0);
        push(5, ref_sum(5), 4, 1'b0);
        expect_rsp(0);
        expect_rsp(0);
        chk("t3_start_count", start_log.size() - n0, 2);
        chk("t3_first_nth", start_log[$-1], 1);
        chk("t3_second_nth", start_log[$], 5);

        // nth=0 bypasses the core
        n0 = start_log.size();
        push(0, 0, 0, 1'b0);
        expect_rsp(0);
        chk("t4_latency", last_wait, 1);
        chk("t4_no_start", start_log.size() - n0, 0);

        // Silent core: timeout after TMO wait cycles
        push(7, 0, 0, 1'b1);
        expect_rsp(0);
        chk("t5_timeout_cycles", rsp_cyc - start_cyc, TMO + 1);

        // Answer lands on the same cycle the timer expires: capture wins
        push(3, ref_sum(3), TMO, 1'b0);
        expect_rsp(0);

        // Fill the FIFO while the consumer stalls
        rsp_ready = 1'b0;
        push(5, 143, 2, 1'b0);
        push(10, 143, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n   = $urandom_range(1, 40);
            ans = ($urandom_range(0, 1) == 0) ? ref_sum(n) : (ref_sum(n) ^ 5);
            push(n, ans, $urandom_range(1, 12), 1'b0);
        end
        chk("t6_req_ready_full", req_ready, 0);
        chk("t6_busy", busy, 1);
        expect_rsp(4);
        for (int i = 0; i < 4; i++) expect_rsp($urandom_range(0, 2));
        chk("t6_idle_after_drain", busy, 0);

        // Randomized requests
        for (int i = 0; i < 12; i++) begin
            n    = $urandom_range(0, 40);
            lat  = $urandom_range(1, TMO);
            mute = ($urandom_range(0, 5) == 0);
            ans  = ($urandom_range(0, 3) == 0) ? (ref_sum(n) ^ int'($urandom_range(1, 1000))) : ref_sum(n);
            push(n, ans, lat, mute);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            expect_rsp($urandom_range(0, 2));
        end

        // Reset in the middle of a calculation, then normal operation resumes
        push(9, 0, 0, 1'b1);
        push(4, ref_sum(4), 2, 1'b0);
        repeat (3) @(negedge clk);
        chk("t7_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        chk("t7_fib_start", fib_start, 0);
        chk("t7_busy", busy, 0);
        chk("t7_rsp_valid", rsp_valid, 0);
        chk("t7_req_ready", req_ready, 1);
        reset = 1'b0;
        exp_q.delete();
        core_q.delete();
        @(negedge clk);
        push(6, ref_sum(6), 2, 1'b0);
        expect_rsp(0);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
